// File: rtl/occupancy_fifo_queue.sv
// Single-clock request FIFO with registered head, occupancy count and almost-full flag.
// Optional FIFO_QUEUE_BYPASS_EN: writes into an empty head register skip storage.
module occupancy_fifo_queue #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int QUEUE_SIZE                 = 6,
    parameter int QUEUE_PTR_WIDTH_IN_BITS    = $clog2(QUEUE_SIZE),
    parameter int OCCUPANCY_WIDTH_IN_BITS    = $clog2(QUEUE_SIZE + 1),
    parameter int ALMOST_FULL_THRESHOLD      = QUEUE_SIZE - 1
) (
    input  logic                                  clk_in,
    input  logic                                  reset_n_in,
    input  logic                                  flush_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                  request_valid_in,
    output logic                                  issue_ack_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
    output logic                                  request_valid_out,
    input  logic                                  issue_ack_in,
    output logic                                  is_empty_out,
    output logic                                  is_full_out,
    output logic                                  is_almost_full_out,
    output logic [OCCUPANCY_WIDTH_IN_BITS-1:0]    occupancy_out
);

    localparam logic [QUEUE_PTR_WIDTH_IN_BITS-1:0] PTR_LAST =
        QUEUE_PTR_WIDTH_IN_BITS'(QUEUE_SIZE - 1);
    localparam logic [OCCUPANCY_WIDTH_IN_BITS-1:0] OCC_FULL =
        OCCUPANCY_WIDTH_IN_BITS'(QUEUE_SIZE);
    localparam logic [OCCUPANCY_WIDTH_IN_BITS-1:0] OCC_ALMOST =
        OCCUPANCY_WIDTH_IN_BITS'(ALMOST_FULL_THRESHOLD);

    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem [QUEUE_SIZE];
    logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    wr_ptr;
    logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    rd_ptr;
    logic [OCCUPANCY_WIDTH_IN_BITS-1:0]    occupancy;
    logic [OCCUPANCY_WIDTH_IN_BITS-1:0]    stored;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] head_data;
    logic                                  head_vld;
    logic                                  push;
    logic                                  pop;
    logic                                  head_free;
    logic                                  stored_nz;
    logic                                  bypass_load;
    logic                                  store_wr;
    logic                                  store_rd;

    function automatic logic [QUEUE_PTR_WIDTH_IN_BITS-1:0] ptr_inc(
        input logic [QUEUE_PTR_WIDTH_IN_BITS-1:0] p
    );
        return (p == PTR_LAST) ? '0 : p + QUEUE_PTR_WIDTH_IN_BITS'(1);
    endfunction

    // Occupancy includes the head register; storage holds the rest.
    assign stored    = occupancy - OCCUPANCY_WIDTH_IN_BITS'(head_vld);
    assign stored_nz = (stored != '0);

    assign is_empty_out       = (occupancy == '0);
    assign is_full_out        = (occupancy == OCC_FULL);
    assign is_almost_full_out = (occupancy >= OCC_ALMOST);
    assign occupancy_out      = occupancy;

    assign pop           = head_vld & issue_ack_in;
    assign issue_ack_out = reset_n_in & ~flush_in & (~is_full_out | pop);
    assign push          = request_valid_in & issue_ack_out;
    assign head_free     = ~head_vld | pop;

`ifdef FIFO_QUEUE_BYPASS_EN
    assign bypass_load = push & head_free & ~stored_nz;
`else
    assign bypass_load = 1'b0;
`endif

    assign store_wr = push & ~bypass_load;
    assign store_rd = head_free & stored_nz;

    assign request_out       = head_data;
    assign request_valid_out = head_vld;

    // Storage array carries no reset; content is qualified by the pointers.
    always_ff @(posedge clk_in) begin
        if (store_wr) begin
            mem[wr_ptr] <= request_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            head_vld  <= 1'b0;
            head_data <= '0;
        end else if (flush_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            head_vld  <= 1'b0;
            head_data <= '0;
        end else begin
            if (store_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (store_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                occupancy <= occupancy + OCCUPANCY_WIDTH_IN_BITS'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - OCCUPANCY_WIDTH_IN_BITS'(1);
            end
            if (bypass_load) begin
                head_data <= request_in;
                head_vld  <= 1'b1;
            end else if (store_rd) begin
                head_data <= mem[rd_ptr];
                head_vld  <= 1'b1;
            end else if (pop) begin
                head_data <= '0;
                head_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/occupancy_fifo_queue.md
# occupancy_fifo_queue

Parametrised successor to the single-clock request FIFO: any depth ≥ 2 (not restricted to powers of 2), registered head output, occupancy count, almost-full threshold and synchronous flush. Sits between request producers and arbiters/issue stages on valid/ack handshakes, where upstream throttling needs early back-pressure rather than a hard full.

## Interface
- SINGLE_ENTRY_WIDTH_IN_BITS, 64, payload width
- QUEUE_SIZE, 6, capacity in entries; any integer ≥ 2
- QUEUE_PTR_WIDTH_IN_BITS, $clog2(QUEUE_SIZE), read/write pointer width
- OCCUPANCY_WIDTH_IN_BITS, $clog2(QUEUE_SIZE+1), occupancy counter width
- ALMOST_FULL_THRESHOLD, QUEUE_SIZE-1, occupancy at which is_almost_full_out asserts; legal range 1..QUEUE_SIZE
- clk_in  in  1  clock, all state on rising edge
- reset_n_in  in  1  asynchronous active-low reset
- flush_in  in  1  synchronous clear of all contents
- request_in  in  SINGLE_ENTRY_WIDTH_IN_BITS  write payload
- request_valid_in  in  1  write request
- issue_ack_out  out  1  write accepted this cycle when high with request_valid_in
- request_out  out  SINGLE_ENTRY_WIDTH_IN_BITS  registered head entry
- request_valid_out  out  1  request_out holds a valid entry
- issue_ack_in  in  1  consumer pops head this cycle
- is_empty_out  out  1  occupancy == 0
- is_full_out  out  1  occupancy == QUEUE_SIZE
- is_almost_full_out  out  1  occupancy ≥ ALMOST_FULL_THRESHOLD
- occupancy_out  out  OCCUPANCY_WIDTH_IN_BITS  entries accepted and not yet popped

## Operation
- Push = request_valid_in & issue_ack_out. Pop = request_valid_out & issue_ack_in.
- issue_ack_out = ~flush_in & (~is_full_out | pop); full-and-popping accepts the write (no lost cycle). Forced 0 while reset_n_in low.
- issue_ack_in without request_valid_out is ignored; occupancy never underflows or exceeds QUEUE_SIZE.
- Occupancy register: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers wrap explicitly: ptr == QUEUE_SIZE-1 → 0 (no reliance on power-of-2 overflow).
- Order strictly FIFO; payload delivered bit-exact.
- Head register reloads on the edge after a pop from the next stored entry, or clears (request_valid_out 0, request_out 0) if none remain.
- flush_in: highest priority; next edge clears pointers, occupancy, head register; concurrent push/pop discarded.
- Asynchronous reset (reset_n_in low) immediately: request_out 0, request_valid_out 0, occupancy_out 0, is_empty_out 1, is_full_out 0, is_almost_full_out 0, pointers 0. Reset mid-transfer drops all content; storage array need not be cleared.
- Status outputs are combinational decodes of the occupancy register.

## Timing
- Push at edge N updates occupancy/status visible after N.
- Latency write→request_valid_out: see Configuration.
- With ≥2 entries stored, sustained pop every cycle; push+pop every cycle at any nonzero occupancy keeps occupancy constant.
- Full + pop + push at same edge: occupancy stays QUEUE_SIZE, new entry queued at tail.
- Exactly 1 entry + push + pop: head reloads with the new entry on the same edge with FIFO_QUEUE_BYPASS_EN, one bubble cycle without.

## Configuration
- FIFO_QUEUE_BYPASS_EN defined: write into a queue whose head register is empty (or being popped with no other entry stored) loads request_in directly into the head register; request_valid_out high the cycle after the push edge (1-cycle latency).
- Undefined: all writes go through storage; head loads from storage one edge later (2-cycle latency from empty, bubble as above). Cuts the request_in→request_out path for timing.

## Test plan
- Reset with reset_n_in low mid-cycle, 3 entries held -> all outputs at reset values immediately, occupancy_out 0, issue_ack_out 0 until release.
- QUEUE_SIZE=6: push 0x11..0x66 with issue_ack_in 0 -> occupancy 5 asserts is_almost_full_out, occupancy 6 asserts is_full_out, issue_ack_out 0; then pop all -> 0x11..0x66 in order, is_empty_out 1.
- Full, simultaneous push 0x77 and pop -> occupancy stays 6, 0x77 delivered after 0x22..0x66.
- Empty, push 0xA5 at edge N -> request_valid_out at N+1 with BYPASS_EN, N+2 without.
- Push/pop every cycle for 20 cycles through wrap of 6-entry pointers -> no bubbles (after fill), no loss, occupancy constant.
- 4 entries held, flush_in with push 0xBB same cycle -> next cycle occupancy 0, request_valid_out 0, 0xBB never emitted.
